// File: rtl/mesh_sort_sequencer_pkg.sv
// rtl/mesh_sort_sequencer_pkg.sv - shared types and constants for the mesh sort sequencer
// Contents:
//   seq_state_e  : sequencer FSM states (IDLE, LOAD, SORT, WRITE, DONE)
//   SEQ_LATENCY  : cycles from an accepted start to the done pulse (N*SC + 3)
package mesh_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SORT  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } seq_state_e;

  function automatic int SEQ_LATENCY(input int n, input int sc);
    return n * sc + 3;
  endfunction

endpackage

// File: rtl/mesh_sort_sequencer_if.sv
// rtl/mesh_sort_sequencer_if.sv - control/enable bundle between sequencer and mesh PEs
// Signals:
//   start, abort  : run request / synchronous cancel (into the sequencer)
//   busy          : run in progress (LOAD, SORT, WRITE)
//   load_en       : PEs latch input words
//   cmp_en        : first cycle of each compare-exchange phase
//   phase_odd     : parity of the current phase
//   phase_idx     : current phase index
//   wr_en         : PEs commit sorted words
//   done          : one-cycle completion pulse
// Modports: master = sequencer side, slave = controller/PE side.
interface mesh_sort_sequencer_if #(
  parameter int PHASE_W = 2
);

  logic               start;
  logic               abort;
  logic               busy;
  logic               load_en;
  logic               cmp_en;
  logic               phase_odd;
  logic [PHASE_W-1:0] phase_idx;
  logic               wr_en;
  logic               done;

  modport master (
    input  start, abort,
    output busy, load_en, cmp_en, phase_odd, phase_idx, wr_en, done
  );

  modport slave (
    output start, abort,
    input  busy, load_en, cmp_en, phase_odd, phase_idx, wr_en, done
  );

endinterface

// File: rtl/mesh_sort_sequencer_phase_counter.sv
// rtl/mesh_sort_sequencer_phase_counter.sv - nested cycle/phase counters for the sort phases
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   clr             : synchronous clear of both counters (wins over en)
//   en              : advance cyc_cnt; on its wrap advance phase_idx
//   cyc_cnt         : cycle within the current phase, 0..SORT_CYCLES-1
//   phase_idx       : current phase, 0..N-1
//   last_phase_end  : final cycle of the final phase
module mesh_phase_counter #(
  parameter int N           = 4,
  parameter int SORT_CYCLES = 4,
  parameter int PHASE_W     = $clog2(N),
  parameter int CYC_W       = $clog2(SORT_CYCLES + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               en,
  output logic [CYC_W-1:0]   cyc_cnt,
  output logic [PHASE_W-1:0] phase_idx,
  output logic               last_phase_end
);

  localparam logic [CYC_W-1:0]   LAST_CYC   = CYC_W'(SORT_CYCLES - 1);
  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(N - 1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_cnt   <= '0;
      phase_idx <= '0;
    end else if (clr) begin
      cyc_cnt   <= '0;
      phase_idx <= '0;
    end else if (en) begin
      if (cyc_cnt == LAST_CYC) begin
        cyc_cnt   <= '0;
        phase_idx <= phase_idx + 1'b1;
      end else begin
        cyc_cnt <= cyc_cnt + 1'b1;
      end
    end
  end

  assign last_phase_end = (phase_idx == LAST_PHASE) && (cyc_cnt == LAST_CYC);

endmodule

// File: rtl/mesh_sort_sequencer.sv
// rtl/mesh_sort_sequencer.sv - central load/sort/write-back phase controller for the mesh
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   seq  : mesh_sort_sequencer_if.master (start/abort in; busy, load_en, cmp_en,
//          phase_odd, phase_idx, wr_en, done out)
// All outputs decode the registered state and counters only.
module mesh_sort_sequencer
  import mesh_seq_pkg::*;
#(
  parameter int N           = 4,
  parameter int SORT_CYCLES = 4,
  parameter int PHASE_W     = $clog2(N)
) (
  input  logic                   clk,
  input  logic                   rst,
  mesh_sort_sequencer_if.master  seq
);

  localparam int CYC_W = $clog2(SORT_CYCLES + 1);

  seq_state_e         state_q;
  seq_state_e         state_d;
  logic [CYC_W-1:0]   cyc_cnt;
  logic [PHASE_W-1:0] phase_idx;
  logic               last_phase_end;
  logic               in_sort;
  logic               cnt_clr;

  assign in_sort = (state_q == SORT);
  // Clearing on the last phase end and on abort keeps both counters at zero
  // everywhere outside SORT, so every SORT entry starts from phase 0.
  assign cnt_clr = !in_sort || last_phase_end || seq.abort;

  mesh_phase_counter #(
    .N           (N),
    .SORT_CYCLES (SORT_CYCLES),
    .PHASE_W     (PHASE_W),
    .CYC_W       (CYC_W)
  ) u_phase_counter (
    .clk            (clk),
    .rst            (rst),
    .clr            (cnt_clr),
    .en             (in_sort),
    .cyc_cnt        (cyc_cnt),
    .phase_idx      (phase_idx),
    .last_phase_end (last_phase_end)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (seq.start) state_d = LOAD;
      LOAD:  state_d = seq.abort ? IDLE : SORT;
      SORT: begin
        if (seq.abort)           state_d = IDLE;
        else if (last_phase_end) state_d = WRITE;
      end
      // wr_en is already driven this cycle; abort only suppresses done.
      WRITE: state_d = seq.abort ? IDLE : DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    seq.busy      = (state_q == LOAD) || in_sort || (state_q == WRITE);
    seq.load_en   = (state_q == LOAD);
    seq.cmp_en    = in_sort && (cyc_cnt == '0);
    seq.phase_odd = in_sort && phase_idx[0];
    seq.phase_idx = in_sort ? phase_idx : '0;
    seq.wr_en     = (state_q == WRITE);
    seq.done      = (state_q == DONE);
  end

endmodule

// File: doc/mesh_sort_sequencer.md
# mesh_sort_sequencer

Central phase controller for the `mesh` sorting fabric. On a start request it sequences every PE through:

- one load cycle;
- `N` odd-even transposition compare-exchange phases of `SORT_CYCLES` cycles each;
- one write-back cycle.

It then signals completion. It sits beside `mesh` and broadcasts its enables to all PEs, replacing the free-running self-sequencing of the PEs.

## Interface
Parameters:
- `N`, 4: number of PEs in the mesh and number of sort phases per run; must be ≥ 2.
- `SORT_CYCLES`, 4: cycles per compare-exchange phase; must be ≥ 1.
- `PHASE_W`, `$clog2(N)`: width of `phase_idx`.

Ports:
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `start`  in  1: run request; sampled only in IDLE.
- `abort`  in  1: synchronous cancel; honoured in every state except IDLE.
- `busy`  out  1: high in LOAD, SORT and WRITE.
- `load_en`  out  1: PEs latch their input words this cycle.
- `cmp_en`  out  1: one-cycle pulse on the first cycle of each phase.
- `phase_odd`  out  1: parity of the current phase, held for the whole phase. 0 pairs PEs (0,1),(2,3)…; 1 pairs PEs (1,2),(3,4)….
- `phase_idx`  out  `PHASE_W`: index of the current phase, 0..N-1.
- `wr_en`  out  1: PEs commit their sorted word to `nanci_init.memory`.
- `done`  out  1: one-cycle completion pulse.

## Operation
- All outputs are Moore and registered: each is a function of state and counters only, with no combinational path from `start` or `abort`.
- States are IDLE, LOAD, SORT, WRITE and DONE.
- IDLE → LOAD when `start`=1. LOAD → SORT unconditionally. SORT → WRITE after phase N-1 ends. WRITE → DONE. DONE → IDLE.
- In SORT, `cyc_cnt` counts 0..SORT_CYCLES-1:
  - `cmp_en` = 1 while `cyc_cnt`==0.
  - On wrap, `phase_idx` increments.
  - `phase_odd` = `phase_idx[0]`.
- SORT_CYCLES=1: `cmp_en` is high on every SORT cycle, and the phase advances every cycle.
- `phase_idx` and `cyc_cnt` clear on entry to SORT and stay 0 outside SORT.
- `abort`=1 in LOAD, SORT, WRITE or DONE → IDLE on the next edge:
  - all outputs return to 0;
  - no `done` pulse and no `wr_en` are issued;
  - if `abort` coincides with the WRITE cycle, `wr_en` has already been driven that cycle and completes; the state still goes to IDLE and `done` is suppressed.
- `start` is ignored outside IDLE. There is no queuing: `start` held through DONE re-launches on the IDLE cycle that follows.
- `start` and `abort` together in IDLE: start wins, because abort has no effect in IDLE.
- Reset (`rst`=0) at any time immediately forces:
  - state IDLE;
  - counters 0;
  - `busy`, `load_en`, `cmp_en`, `phase_odd`, `phase_idx`, `wr_en`, `done` all = 0.

## Timing
- Time `start` sampled high in IDLE at edge t (cycle 0). Then:
  - `load_en` is high in cycle 1.
  - Phase k occupies cycles 2+k·SC .. 1+(k+1)·SC, and `cmp_en` is high at cycle 2+k·SC.
  - `wr_en` is high at cycle 2+N·SC.
  - `done` is high at cycle 3+N·SC.
  - The block is back in IDLE at cycle 4+N·SC.
- Latency from start to done is N·SC+3 cycles. The minimum start-to-start period is N·SC+4.
- `busy` rises in cycle 1 and falls after the WRITE cycle; it is low during the `done` cycle.
- Exactly one of `load_en`, `cmp_en`, `wr_en`, `done` may be high in any cycle.
- SORT_CYCLES=1: `cmp_en` is continuous from cycle 2 to cycle N+1.

## Structure
- Package `mesh_seq_pkg` holds:
  - the state enum (IDLE, LOAD, SORT, WRITE, DONE);
  - a `SEQ_LATENCY(N,SC)` = N·SC+3 helper constant, shared by RTL and bench.
- One sub-module, `mesh_phase_counter`, holds the nested `cyc_cnt`/`phase_idx` counters with clear and enable inputs.
  - `cyc_cnt` width is `$clog2(SORT_CYCLES+1)`.
  - It flags `last_phase_end` when `phase_idx`==N-1 and `cyc_cnt`==SC-1.
- The top level holds the FSM and output decode.

## Test plan
- N=4, SC=4, `start` pulse at cycle 0:
  - `load_en`@1;
  - `cmp_en`@2,6,10,14 with `phase_odd` 0,1,0,1 and `phase_idx` 0..3;
  - `wr_en`@18, `done`@19, `busy` high for cycles 1–18.
- Mesh integration with N=4 and reversed input, driven by the sequencer: `nanci_init.memory` of PE k equals 3-k after `done`.
- `abort` at cycle 9, mid-phase 1: IDLE at cycle 10, all outputs 0, no `wr_en` and no `done`. A new `start` at cycle 11 yields `done` at cycle 30.
- `rst` asserted asynchronously at cycle 7 between edges: outputs are 0 immediately, `busy` is 0 while `rst`=0, and the restart timing matches the first scenario.
- `start` held high continuously:
  - `done`@19;
  - IDLE@20, then the start is accepted again, giving `load_en`@21;
  - start pulses arriving during busy cycles are never double-counted.
- SC=1, N=2: `cmp_en`@2,3; `wr_en`@4; `done`@5.
